// File: rtl/color_sensor_if.sv
// Control/observation bundle between the colour detector (master) and the
// TCS3200 emulator (slave).
interface color_sensor_if #(
  parameter int HALF_WIDTH = 16
);
  logic                  enable;
  logic [1:0]            colorSelect;
  logic                  loadStrobe;
  logic [1:0]            loadSelect;
  logic [HALF_WIDTH-1:0] loadValue;
  logic                  frequencyToDetector;
  logic                  settling;
  logic [7:0]            edgeCount;

  modport master (
    output enable, colorSelect, loadStrobe, loadSelect, loadValue,
    input  frequencyToDetector, settling, edgeCount
  );

  modport slave (
    input  enable, colorSelect, loadStrobe, loadSelect, loadValue,
    output frequencyToDetector, settling, edgeCount
  );
endinterface

// File: rtl/color_sensor_emulator.sv
// TCS3200 stand-in: square wave whose half-period is chosen by {S3,S2},
// with a settle interval after every enable or filter change.
module color_sensor_emulator #(
  parameter int HALF_WIDTH         = 16,
  parameter int SETTLE_CYCLES      = 64,
  parameter int RED_HALF_DEFAULT   = 100,
  parameter int GREEN_HALF_DEFAULT = 200,
  parameter int BLUE_HALF_DEFAULT  = 300,
  parameter int CLEAR_HALF_DEFAULT = 50
) (
  input  logic           i_clk,
  input  logic           i_reset,
  color_sensor_if.slave  bus
);

  // state    | meaning
  // S_IDLE   | disabled, output low
  // S_SETTLE | filter settling, output low, settle counter running
  // S_RUN    | square wave at half[colorSelect]
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t                r_state;
  logic                  r_freq;
  logic [SETTLE_W-1:0]   r_settle_cnt;
  logic [HALF_WIDTH-1:0] r_half_cnt;
  logic [HALF_WIDTH-1:0] r_half [4];
  logic [1:0]            r_prev_sel;
  logic [7:0]            r_edge_cnt;

  state_t                w_state_nxt;
  logic                  w_freq_nxt;
  logic [SETTLE_W-1:0]   w_settle_nxt;
  logic [HALF_WIDTH-1:0] w_half_cnt_nxt;
  logic [HALF_WIDTH-1:0] w_load_val;
  logic [HALF_WIDTH-1:0] w_half_act;
  logic                  w_sel_change;
  logic                  w_rise;

  assign w_load_val   = (bus.loadValue == '0) ? HALF_WIDTH'(1) : bus.loadValue;
  assign w_sel_change = (bus.colorSelect != r_prev_sel);

  // A same-cycle load to the active colour feeds the compare directly.
  assign w_half_act = (bus.loadStrobe && (bus.loadSelect == bus.colorSelect))
                      ? w_load_val : r_half[bus.colorSelect];

  always_comb begin
    w_state_nxt    = r_state;
    w_freq_nxt     = r_freq;
    w_settle_nxt   = r_settle_cnt;
    w_half_cnt_nxt = r_half_cnt;
    case (r_state)
      S_IDLE: begin
        w_freq_nxt = 1'b0;
        if (bus.enable) begin
          w_state_nxt  = S_SETTLE;
          w_settle_nxt = '0;
        end
      end
      S_SETTLE: begin
        w_freq_nxt = 1'b0;
        if (!bus.enable) begin
          w_state_nxt = S_IDLE;
        end else if (w_sel_change) begin
          w_settle_nxt = '0;
        end else if (r_settle_cnt == SETTLE_LAST) begin
          w_state_nxt    = S_RUN;
          w_freq_nxt     = 1'b1;
          w_half_cnt_nxt = '0;
        end else begin
          w_settle_nxt = r_settle_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (!bus.enable) begin
          w_state_nxt = S_IDLE;
          w_freq_nxt  = 1'b0;
        end else if (w_sel_change) begin
          w_state_nxt  = S_SETTLE;
          w_settle_nxt = '0;
          w_freq_nxt   = 1'b0;
        end else if (r_half_cnt >= (w_half_act - 1'b1)) begin
          // >= so a shortened half-period ends at once instead of wrapping
          w_freq_nxt     = ~r_freq;
          w_half_cnt_nxt = '0;
        end else begin
          w_half_cnt_nxt = r_half_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_freq_nxt  = 1'b0;
      end
    endcase
  end

  assign w_rise = w_freq_nxt & ~r_freq;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_freq       <= 1'b0;
      r_settle_cnt <= '0;
      r_half_cnt   <= '0;
      r_prev_sel   <= bus.colorSelect;
      r_edge_cnt   <= '0;
      r_half[0]    <= HALF_WIDTH'(RED_HALF_DEFAULT);
      r_half[1]    <= HALF_WIDTH'(CLEAR_HALF_DEFAULT);
      r_half[2]    <= HALF_WIDTH'(BLUE_HALF_DEFAULT);
      r_half[3]    <= HALF_WIDTH'(GREEN_HALF_DEFAULT);
    end else begin
      r_state      <= w_state_nxt;
      r_freq       <= w_freq_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_half_cnt   <= w_half_cnt_nxt;
      r_prev_sel   <= bus.colorSelect;
      if (bus.loadStrobe) r_half[bus.loadSelect] <= w_load_val;
      if (w_rise) r_edge_cnt <= r_edge_cnt + 8'd1;
    end
  end

  assign bus.frequencyToDetector = r_freq;
  assign bus.settling            = (r_state == S_SETTLE);
  assign bus.edgeCount           = r_edge_cnt;

endmodule

// File: tb/tb_color_sensor_emulator.sv
// Bench for color_sensor_emulator: expected phase lengths are queued when
// stimulus is applied and popped as each output phase is measured.
module tb_color_sensor_emulator;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   q[$];

  color_sensor_if #(.HALF_WIDTH(16)) bus ();

  color_sensor_emulator #(
    .HALF_WIDTH(16), .SETTLE_CYCLES(64),
    .RED_HALF_DEFAULT(100), .GREEN_HALF_DEFAULT(200),
    .BLUE_HALF_DEFAULT(300), .CLEAR_HALF_DEFAULT(50)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles the chosen signal stays at lvl; start counts cycles already seen.
  task automatic count_level(input bit use_settle, input logic lvl,
                             input int start, output int n);
    logic s;
    bit   done;
    n    = start;
    done = 1'b0;
    for (int g = 0; g < 5000 && !done; g++) begin
      tick();
      s = use_settle ? bus.settling : bus.frequencyToDetector;
      if (s !== lvl) done = 1'b1;
      else n++;
    end
    if (!done) n = -1;
  endtask

  task automatic load(input logic [1:0] sel, input logic [15:0] val);
    bus.loadStrobe = 1'b1;
    bus.loadSelect = sel;
    bus.loadValue  = val;
    tick();
    bus.loadStrobe = 1'b0;
  endtask

  task automatic test_reset();
    int exp_v;
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.colorSelect = 2'b00;
    bus.loadStrobe = 1'b0;
    bus.loadSelect = 2'b00;
    bus.loadValue = '0;
    repeat (3) tick();
    bus.enable = 1'b1;
    tick();
    checks++;
    if (bus.frequencyToDetector !== 1'b0) begin
      errors++; $display("FAIL reset_freq got %b expected 0", bus.frequencyToDetector);
    end
    checks++;
    if (bus.settling !== 1'b0) begin
      errors++; $display("FAIL reset_settling got %b expected 0", bus.settling);
    end
    exp_v = 0;
    checks++;
    if (bus.edgeCount !== 8'(exp_v)) begin
      errors++; $display("FAIL reset_edges got %0d expected %0d", bus.edgeCount, exp_v);
    end
  endtask

  task automatic test_red();
    int n, exp_v;
    q.push_back(64); q.push_back(100); q.push_back(100);
    reset = 1'b0;
    tick();
    checks++;
    if (bus.settling !== 1'b1) begin
      errors++; $display("FAIL red_settle_start got %b expected 1", bus.settling);
    end
    count_level(1'b1, 1'b1, 1, n);
    exp_v = q.pop_front();
    checks++;
    if (n !== exp_v) begin
      errors++; $display("FAIL red_settle_len got %0d expected %0d", n, exp_v);
    end
    checks++;
    if (bus.frequencyToDetector !== 1'b1 || bus.edgeCount !== 8'd1) begin
      errors++; $display("FAIL red_first_edge got freq %b edges %0d expected 1 1",
                         bus.frequencyToDetector, bus.edgeCount);
    end
    for (int i = 0; i < 2; i++) begin
      count_level(1'b0, (i == 0) ? 1'b1 : 1'b0, 1, n);
      exp_v = q.pop_front();
      checks++;
      if (n !== exp_v) begin
        errors++; $display("FAIL red_phase%0d got %0d expected %0d", i, n, exp_v);
      end
    end
  endtask

  task automatic test_switch_green();
    int n, exp_v;
    q.push_back(64); q.push_back(200); q.push_back(200);
    repeat (30) tick();
    bus.colorSelect = 2'b11;
    tick();
    checks++;
    if (bus.frequencyToDetector !== 1'b0 || bus.settling !== 1'b1) begin
      errors++; $display("FAIL switch_immediate got freq %b settling %b expected 0 1",
                         bus.frequencyToDetector, bus.settling);
    end
    count_level(1'b1, 1'b1, 1, n);
    exp_v = q.pop_front();
    checks++;
    if (n !== exp_v) begin
      errors++; $display("FAIL green_settle_len got %0d expected %0d", n, exp_v);
    end
    for (int i = 0; i < 2; i++) begin
      count_level(1'b0, (i == 0) ? 1'b1 : 1'b0, 1, n);
      exp_v = q.pop_front();
      checks++;
      if (n !== exp_v) begin
        errors++; $display("FAIL green_phase%0d got %0d expected %0d", i, n, exp_v);
      end
    end
  endtask

  task automatic test_load_blue();
    int n, exp_v;
    q.push_back(64); q.push_back(1); q.push_back(1); q.push_back(1);
    load(2'b10, 16'd0);
    bus.colorSelect = 2'b10;
    tick();
    count_level(1'b1, 1'b1, 1, n);
    exp_v = q.pop_front();
    checks++;
    if (n !== exp_v) begin
      errors++; $display("FAIL blue_settle_len got %0d expected %0d", n, exp_v);
    end
    for (int i = 0; i < 3; i++) begin
      count_level(1'b0, (i % 2 == 0) ? 1'b1 : 1'b0, 1, n);
      exp_v = q.pop_front();
      checks++;
      if (n !== exp_v) begin
        errors++; $display("FAIL blue_zero_phase%0d got %0d expected %0d", i, n, exp_v);
      end
    end
    // Now one cycle into a low phase; load 7 stretches it to 7 cycles.
    q.push_back(7); q.push_back(7); q.push_back(7);
    load(2'b10, 16'd7);
    for (int i = 0; i < 3; i++) begin
      count_level(1'b0, (i % 2 == 0) ? 1'b0 : 1'b1, (i == 0) ? 2 : 1, n);
      exp_v = q.pop_front();
      checks++;
      if (n !== exp_v) begin
        errors++; $display("FAIL blue_seven_phase%0d got %0d expected %0d", i, n, exp_v);
      end
    end
  endtask

  task automatic test_red_load();
    int n, exp_v;
    q.push_back(64); q.push_back(20); q.push_back(20);
    bus.colorSelect = 2'b00;
    tick();
    count_level(1'b1, 1'b1, 1, n);
    exp_v = q.pop_front();
    checks++;
    if (n !== exp_v) begin
      errors++; $display("FAIL red2_settle_len got %0d expected %0d", n, exp_v);
    end
    repeat (50) tick();
    checks++;
    if (bus.frequencyToDetector !== 1'b1) begin
      errors++; $display("FAIL red_mid_high got %b expected 1", bus.frequencyToDetector);
    end
    load(2'b00, 16'd20);
    checks++;
    if (bus.frequencyToDetector !== 1'b0) begin
      errors++; $display("FAIL red_short_toggle got %b expected 0", bus.frequencyToDetector);
    end
    for (int i = 0; i < 2; i++) begin
      count_level(1'b0, (i == 0) ? 1'b0 : 1'b1, 1, n);
      exp_v = q.pop_front();
      checks++;
      if (n !== exp_v) begin
        errors++; $display("FAIL red20_phase%0d got %0d expected %0d", i, n, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int n, exp_v;
    q.push_back(64); q.push_back(100);
    repeat (5) tick();
    reset = 1'b1;
    bus.loadStrobe = 1'b1;
    bus.loadSelect = 2'b00;
    bus.loadValue  = 16'd5;
    tick();
    bus.loadStrobe = 1'b0;
    checks++;
    if (bus.frequencyToDetector !== 1'b0 || bus.edgeCount !== 8'd0 || bus.settling !== 1'b0) begin
      errors++; $display("FAIL midrun_reset got freq %b edges %0d settling %b expected 0 0 0",
                         bus.frequencyToDetector, bus.edgeCount, bus.settling);
    end
    reset = 1'b0;
    tick();
    count_level(1'b1, 1'b1, 1, n);
    exp_v = q.pop_front();
    checks++;
    if (n !== exp_v) begin
      errors++; $display("FAIL post_reset_settle got %0d expected %0d", n, exp_v);
    end
    count_level(1'b0, 1'b1, 1, n);
    exp_v = q.pop_front();
    checks++;
    if (n !== exp_v) begin
      errors++; $display("FAIL red_default_restored got %0d expected %0d", n, exp_v);
    end
  endtask

  task automatic test_clear_wrap();
    int n, exp_v;
    q.push_back(64);
    reset = 1'b1;
    bus.colorSelect = 2'b01;
    tick();
    reset = 1'b0;
    tick();
    count_level(1'b1, 1'b1, 1, n);
    exp_v = q.pop_front();
    checks++;
    if (n !== exp_v) begin
      errors++; $display("FAIL clear_settle_len got %0d expected %0d", n, exp_v);
    end
    repeat (254 * 100) tick();
    checks++;
    if (bus.frequencyToDetector !== 1'b1 || bus.edgeCount !== 8'd255) begin
      errors++; $display("FAIL clear_edge255 got freq %b edges %0d expected 1 255",
                         bus.frequencyToDetector, bus.edgeCount);
    end
    repeat (100) tick();
    checks++;
    if (bus.frequencyToDetector !== 1'b1 || bus.edgeCount !== 8'd0) begin
      errors++; $display("FAIL clear_wrap got freq %b edges %0d expected 1 0",
                         bus.frequencyToDetector, bus.edgeCount);
    end
  endtask

  task automatic test_enable_drop();
    int n, exp_v;
    q.push_back(64); q.push_back(300);
    repeat (20) tick();
    bus.enable = 1'b0;
    bus.colorSelect = 2'b10;
    tick();
    checks++;
    if (bus.frequencyToDetector !== 1'b0 || bus.settling !== 1'b0) begin
      errors++; $display("FAIL enable_drop got freq %b settling %b expected 0 0",
                         bus.frequencyToDetector, bus.settling);
    end
    repeat (10) tick();
    checks++;
    if (bus.frequencyToDetector !== 1'b0 || bus.settling !== 1'b0 || bus.edgeCount !== 8'd0) begin
      errors++; $display("FAIL idle_hold got freq %b settling %b edges %0d expected 0 0 0",
                         bus.frequencyToDetector, bus.settling, bus.edgeCount);
    end
    bus.enable = 1'b1;
    tick();
    count_level(1'b1, 1'b1, 1, n);
    exp_v = q.pop_front();
    checks++;
    if (n !== exp_v) begin
      errors++; $display("FAIL reenable_settle got %0d expected %0d", n, exp_v);
    end
    checks++;
    if (bus.edgeCount !== 8'd1) begin
      errors++; $display("FAIL reenable_edges got %0d expected 1", bus.edgeCount);
    end
    count_level(1'b0, 1'b1, 1, n);
    exp_v = q.pop_front();
    checks++;
    if (n !== exp_v) begin
      errors++; $display("FAIL blue_default_high got %0d expected %0d", n, exp_v);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_red();
    test_switch_green();
    test_load_blue();
    test_red_load();
    test_reset_mid_run();
    test_clear_wrap();
    test_enable_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/color_sensor_emulator.md
Name: color_sensor_emulator

Overview:
Synthesizable stand-in for the TCS3200 colour sensor: drives a square wave whose period depends on the {S3,S2} colour-select code from the detector. Used on the bench and in hardware bring-up to feed the colour detector known frequencies without a physical sensor or acrylic. Half-periods per filter are programmable at runtime through a simple load strobe. Select changes trigger a settle interval, mimicking the sensor's settling after a filter change.

Parameters:
HALF_WIDTH, 16, width of half-period counters and registers
SETTLE_CYCLES, 64, cycles output is held low after a select change or enable; minimum 1
RED_HALF_DEFAULT, 100, reset half-period for code 2'b00
GREEN_HALF_DEFAULT, 200, reset half-period for code 2'b11
BLUE_HALF_DEFAULT, 300, reset half-period for code 2'b10
CLEAR_HALF_DEFAULT, 50, reset half-period for code 2'b01 (no filter)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  emulator output enable
colorSelect  in  2  {S3,S2} from the detector: 00 red, 11 green, 10 blue, 01 clear
loadStrobe  in  1  one-cycle write of a half-period register
loadSelect  in  2  register to write, same encoding as colorSelect
loadValue  in  HALF_WIDTH  new half-period in clk cycles
frequencyToDetector  out  1  emulated sensor square wave
settling  out  1  high while in SETTLE
edgeCount  out  8  debug: rising edges of frequencyToDetector, wraps

Behaviour:
- Reset (synchronous, active-high): state IDLE; frequencyToDetector=0; settling=0; edgeCount=0; half-period registers = *_DEFAULT; counters=0; prevSelect=colorSelect. Reset overrides every other input.
- Half-period registers: four registers, indexed by the colour code. A loadStrobe cycle writes loadValue into the register selected by loadSelect; loadValue 0 stores 1. Loads are accepted in every state.
- State machine:
  - IDLE: output 0, settling 0. When enable=1 -> SETTLE next cycle, settleCnt=0.
  - SETTLE: output 0, settling 1, settleCnt increments. When settleCnt==SETTLE_CYCLES-1 -> RUN next cycle; on that transition frequencyToDetector<=1 and halfCnt<=0. The transition counts as a rising edge.
  - RUN: halfCnt increments. When halfCnt==half[colorSelect]-1, frequencyToDetector toggles and halfCnt<=0. Each level lasts exactly half[colorSelect] cycles. Period = 2*half.
- Select change: prevSelect registers colorSelect every cycle. If colorSelect!=prevSelect in SETTLE or RUN -> SETTLE next cycle, settleCnt=0, output 0. In IDLE a change is only tracked.
- enable=0 in any state -> IDLE next cycle, output 0. This takes priority over select change.
- Priority, highest first: reset > enable low > select change > settle/half-period terminal count.
- A load to the active colour during RUN takes effect on the current compare immediately. If the new value is at or below the current halfCnt+1, toggle on the next cycle: the compare is >=, not ==.
- edgeCount increments on each 0->1 transition of frequencyToDetector. It wraps 255->0 and is never cleared except by reset.
- Select code 01 (clear) runs like the others, using the clear register.

Test Plan:
- Reset, enable=1, colorSelect=00 -> settling=1 for 64 cycles; output then high 100 cycles, low 100, repeating; edgeCount=1 at first high.
- Switch colorSelect 00->11 mid-high-phase -> output 0 next cycle, settling for 64 cycles, then high 200/low 200.
- loadStrobe loadSelect=10 loadValue=0, then select 10 -> period 2 cycles (toggle every cycle). Load 7 -> high 7/low 7.
- In RUN red at halfCnt=50, load red=20 -> toggle on next cycle, then 20-cycle halves.
- Run select 01 with default 50 for 256 rising edges -> edgeCount wraps to 0. Drop enable mid-phase -> output 0 next cycle, state IDLE.
- Assert reset mid-RUN with modified registers -> next cycle output 0, edgeCount 0, red register back to 100.
